shift_register_universal: RTL
=============================

# shift_register_universal

Parametrised universal shift register with an automatic burst engine. It supports manual hold, shift-right, shift-left and parallel-load operations. It also runs a self-timed full-duplex burst: one WIDTH-bit word is loaded and shifted out serially while WIDTH serial input bits are captured in the same cycles. The block is the general serialiser/deserialiser for the shift-register family and sits between parallel datapaths and single-bit serial links.

## Interface
- WIDTH, 8: register width; legal range ≥ 2.
- MSB_FIRST, 1: burst direction.
  - 1: shift left; ser_out = q[WIDTH-1]; ser_in enters LSB.
  - 0: shift right; ser_out = q[0]; ser_in enters MSB.

- clk  in  1  rising-edge clock; single clock domain.
- clear  in  1  reset, asynchronous, active-high.
- en  in  1  enable for manual modes; ignored during a burst.
- mode  in  2  manual op: 00 hold, 01 shift right (ser_in → MSB), 10 shift left (ser_in → LSB), 11 parallel load.
- ser_in  in  1  serial input bit.
- par_in  in  WIDTH  parallel load word.
- start  in  1  burst request, sampled in IDLE.
- q  out  WIDTH  register contents.
- ser_out  out  1  serial output; combinational from q per MSB_FIRST.
- busy  out  1  high while in BURST.
- done  out  1  one-cycle pulse after the final burst shift.
- cnt  out  $clog2(WIDTH+1)  shifts completed in the current or last burst.

## Operation
- Reset values (clear=1, immediate, edge-independent): q=0, ser_out=0, busy=0, done=0, cnt=0, state=IDLE.
- FSM states: IDLE, BURST.
- IDLE, start=1:
  - q←par_in, cnt←0, state→BURST.
  - start has priority over en/mode.
- IDLE, start=0, en=1: apply mode. Shift right is q←{ser_in, q[WIDTH-1:1]}; shift left is q←{q[WIDTH-2:0], ser_in}.
- IDLE, start=0, en=0: hold.
- BURST, each edge:
  - Shift in MSB_FIRST direction, capturing ser_in; cnt←cnt+1.
  - When cnt reaches WIDTH: state→IDLE, done=1 for that one cycle.
- BURST ignores start, en and mode. No queuing.
- cnt holds WIDTH after a burst until the next start or clear; manual ops do not change cnt.
- done is high only in the first IDLE cycle after a burst. It clears on the next edge regardless of inputs.
- Boundaries:
  - start in the done cycle: accepted (back-to-back). busy is low for exactly that one cycle.
  - clear mid-burst: abort, reset values, no done pulse. The next start behaves normally.

## Timing
- Start edge E0 (start=1 sampled): q=par_in, busy=1 from E0.
- Cycles between E0..E1 through E(WIDTH-1)..E(WIDTH):
  - ser_out presents burst bit k (k=0..WIDTH-1), first bit = MSB if MSB_FIRST.
  - ser_in is sampled at each edge E1..EWIDTH.
- E(WIDTH):
  - busy=0, done=1, cnt=WIDTH.
  - q holds the WIDTH captured ser_in bits; the first captured bit sits at the far end (MSB if MSB_FIRST).
- Burst latency start→done: WIDTH+1 edges. Throughput: one word per WIDTH+1 cycles back-to-back.
- Manual ops: one edge latency; q updates at the sampling edge.
- ser_out has no register stage; it follows q in the same cycle.

## Structure
- Shared package shift_reg_pkg:
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
  - state encoding ST_IDLE, ST_BURST.
- One sub-module, shift_reg_core: WIDTH-bit register with op select (hold/shr/shl/load), ser_in and par_in. The top holds the FSM and cnt and drives the core's op.

## Test plan
- WIDTH=8. Pulse clear asynchronously between edges with q=8'hFF mid-burst → q, busy, done, cnt, ser_out all 0 before the next edge; no done pulse follows.
- en=1, mode=11, par_in=8'hA5 → q=A5. Then mode=01, ser_in=1 → q=D2. Then mode=10, ser_in=0 → q=A4. Then en=0 → q holds A4.
- MSB_FIRST=1, start with par_in=8'hB4, ser_in stream 1,0,1,0,1,0,1,1 → ser_out 1,0,1,1,0,1,0,0; busy high 8 cycles; then done high 1 cycle with q=8'hAB, cnt=8.
- Hold start=1 and mode=11, par_in=8'h00 through a burst → burst unaffected. start=1 in the done cycle → new burst loads; busy low exactly one cycle.
- clear at cycle 4 of a burst, then start with par_in=8'h3C → clean full burst, ser_out 0,0,1,1,1,1,0,0, done after 8 shifts.
- MSB_FIRST=0, par_in=8'hB4 → ser_out 0,0,1,0,1,1,0,1. ser_in stream 1,1,0,0,0,0,0,0 → final q=8'h03.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register family: manual op codes and burst FSM states.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // MSB-first bursts shift toward the MSB so q[WIDTH-1] is presented first.
    function automatic mode_e burst_op(input bit msb_first);
        return msb_first ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit register with hold / shift-right / shift-left / parallel-load op select.
module shift_reg_core
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  mode_e            i_op,
    input  logic             i_ser_in,
    input  logic [WIDTH-1:0] i_par_in,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_q <= '0;
        end else begin
            case (i_op)
                MODE_HOLD: r_q <= r_q;
                MODE_SHR:  r_q <= {i_ser_in, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], i_ser_in};
                MODE_LOAD: r_q <= i_par_in;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register with a self-timed full-duplex burst engine (load, then WIDTH shifts).
module shift_register_universal #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       ser_in,
    input  logic [WIDTH-1:0]           par_in,
    input  logic                       start,
    output logic [WIDTH-1:0]           q,
    output logic                       ser_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] cnt
);

    import shift_reg_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam mode_e            BURST_OP = burst_op(MSB_FIRST);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_done;
    logic             w_done_next;
    mode_e            w_op;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Start wins over manual ops; a burst ignores every control input until its last shift.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_op         = MODE_HOLD;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op         = MODE_LOAD;
                    w_cnt_next   = '0;
                    w_state_next = ST_BURST;
                end else if (en) begin
                    w_op = mode_e'(mode);
                end
            end
            ST_BURST: begin
                w_op       = BURST_OP;
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .clear    (clear),
        .i_op     (w_op),
        .i_ser_in (ser_in),
        .i_par_in (par_in),
        .o_q      (q)
    );

    assign ser_out = MSB_FIRST ? q[WIDTH-1] : q[0];
    assign busy    = (r_state == ST_BURST);
    assign done    = r_done;
    assign cnt     = r_cnt;

endmodule
